// File: rtl/seg7_scan_driver_if.sv
// Bundles the capture inputs and the scan outputs of the seven-segment driver.
// Pure wiring: no storage and no added latency.
// No backpressure: the update strobe is always accepted.
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        update;
  logic [1:0]  digit_sel;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  // Producer of display data, consumer of the scan outputs.
  modport master (
    output value, dp_in, digit_en, update,
    input  digit_sel, seg_n, dp_n, frame_done
  );

  // The scan driver itself.
  modport slave (
    input  value, dp_in, digit_en, update,
    output digit_sel, seg_n, dp_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scanner with frame-aligned commit of captured data.
// Outputs registered; index and cathodes change together. New data shows from the first slot of the next frame.
// No backpressure: update is a strobe that is always accepted, last write before the wrap wins.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic           clk,
  input logic           rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   stg_value_q, stg_value_d;
  logic [3:0]    stg_dp_q, stg_dp_d;
  logic [3:0]    stg_en_q, stg_en_d;
  logic          pending_q, pending_d;
  logic [15:0]   disp_value_q, disp_value_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [3:0]    disp_en_q, disp_en_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;

  logic          slot_end;
  logic          wrap;
  logic          in_blank;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Slot timing: prescaler runs per slot, digit index advances at slot end, frame wraps after digit 3.
  always_comb begin
    slot_end     = (prescaler_q == PW'(REFRESH_DIV - 1));
    wrap         = slot_end && (digit_sel_q == 2'd3);
    prescaler_d  = slot_end ? '0 : prescaler_q + PW'(1);
    digit_sel_d  = slot_end ? digit_sel_q + 2'd1 : digit_sel_q;
    frame_done_d = wrap;
  end

  // Capture into staging on update; commit to display only on the frame wrap.
  // An update landing on the wrap edge bypasses staging so it is shown in the frame that starts now.
  always_comb begin
    stg_value_d  = stg_value_q;
    stg_dp_d     = stg_dp_q;
    stg_en_d     = stg_en_q;
    pending_d    = pending_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_en_d    = disp_en_q;
    if (bus.update) begin
      stg_value_d = bus.value;
      stg_dp_d    = bus.dp_in;
      stg_en_d    = bus.digit_en;
      pending_d   = 1'b1;
    end
    if (wrap) begin
      pending_d = 1'b0;
      if (bus.update) begin
        disp_value_d = bus.value;
        disp_dp_d    = bus.dp_in;
        disp_en_d    = bus.digit_en;
      end else if (pending_q) begin
        disp_value_d = stg_value_q;
        disp_dp_d    = stg_dp_q;
        disp_en_d    = stg_en_q;
      end
    end
  end

  // Ghost-suppression window at the start of each slot; absent entirely when BLANK_CYCLES is 0.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (prescaler_d < PW'(BLANK_CYCLES));
  end

  // Cathodes are computed from next-state index/prescaler/display so they register in lockstep with digit_sel.
  always_comb begin
    case (digit_sel_d)
      2'd0:    nibble = disp_value_d[3:0];
      2'd1:    nibble = disp_value_d[7:4];
      2'd2:    nibble = disp_value_d[11:8];
      default: nibble = disp_value_d[15:12];
    endcase
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (!in_blank && disp_en_d[digit_sel_d]) begin
      seg_n_d = hex7(nibble);
      dp_n_d  = ~disp_dp_d[digit_sel_d];
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q  <= '0;
      digit_sel_q  <= 2'd0;
      frame_done_q <= 1'b0;
      stg_value_q  <= 16'h0;
      stg_dp_q     <= 4'h0;
      stg_en_q     <= 4'h0;
      pending_q    <= 1'b0;
      disp_value_q <= 16'h0;
      disp_dp_q    <= 4'h0;
      disp_en_q    <= 4'h0;
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
      stg_value_q  <= stg_value_d;
      stg_dp_q     <= stg_dp_d;
      stg_en_q     <= stg_en_d;
      pending_q    <= pending_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_en_q    <= disp_en_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
    end
  end

  assign bus.digit_sel  = digit_sel_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV = 8, BLANK_CYCLES = 2.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Table of display vectors plus hand sequences for reset, multi-update, wrap-edge update and async reset.
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      en;
    logic [3:0][6:0] seg;  // expected pattern per digit, index = digit
    logic [3:0]      dpn;  // expected dp_n per digit
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Follow one whole frame starting at the post-wrap cycle; ends sampled in the last cycle of digit 3.
  task automatic check_frame(input string tag, input logic [3:0][6:0] seg_e, input logic [3:0] dpn_e);
    for (int c = 0; c < 32; c++) begin
      int d;
      int s;
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      d = c / 8;
      s = c % 8;
      chk($sformatf("%s sel c%0d", tag, c), 32'(bus.digit_sel), 32'(d));
      chk($sformatf("%s seg c%0d", tag, c), 32'(bus.seg_n), (s < 2) ? 32'h7F : 32'(seg_e[d]));
      chk($sformatf("%s dp c%0d", tag, c), 32'(bus.dp_n), (s < 2) ? 32'h1 : 32'(dpn_e[d]));
      chk($sformatf("%s fdone c%0d", tag, c), 32'(bus.frame_done), (c == 0) ? 32'h1 : 32'h0);
    end
  endtask

  // Wait (bounded) for frame_done; optionally require a fully blank display while waiting.
  task automatic wait_frame(input string tag, input bit chk_blank);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 80 && !got; n++) begin
      @(posedge clk);
      #1;
      if (chk_blank) begin
        chk($sformatf("%s pre-wrap seg", tag), 32'(bus.seg_n), 32'h7F);
        chk($sformatf("%s pre-wrap dp", tag), 32'(bus.dp_n), 32'h1);
      end
      if (bus.frame_done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s frame_done timeout: got 0, expected 1 within 80 cycles", tag);
    end
  endtask

  // After reset release, run n edges with a blank display and check the index walk and frame_done.
  task automatic check_after_reset(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s sel k%0d", tag, k), 32'(bus.digit_sel), 32'((k / 8) % 4));
      chk($sformatf("%s seg k%0d", tag, k), 32'(bus.seg_n), 32'h7F);
      chk($sformatf("%s fdone k%0d", tag, k), 32'(bus.frame_done), (k == 32) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic pulse_update(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    @(negedge clk);
    bus.value    = v;
    bus.dp_in    = dp;
    bus.digit_en = en;
    bus.update   = 1'b1;
    @(negedge clk);
    bus.update   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b1;
    bus.value = 16'h0;
    bus.dp_in = 4'h0;
    bus.digit_en = 4'h0;
    bus.update = 1'b0;

    vecs[0] = '{16'h1234, 4'b0000, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'h00F0, 4'b0001, 4'b0011, {7'h7F, 7'h7F, 7'h0E, 7'h40}, 4'b1110};
    vecs[2] = '{16'h5678, 4'b1010, 4'b1111, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0101};
    vecs[3] = '{16'h9ABC, 4'b0100, 4'b1101, {7'h10, 7'h08, 7'h7F, 7'h46}, 4'b1011};
    vecs[4] = '{16'hDEF0, 4'b0000, 4'b1111, {7'h21, 7'h06, 7'h0E, 7'h40}, 4'b1111};

    // Reset held for 3 cycles, then released between edges.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sel", 32'(bus.digit_sel), 32'h0);
    chk("reset seg", 32'(bus.seg_n), 32'h7F);
    chk("reset dp", 32'(bus.dp_n), 32'h1);
    chk("reset fdone", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_after_reset("post-reset", 8);

    // Table: capture mid-frame, nothing shows before the wrap, then one full frame of patterns.
    for (int i = 0; i < 5; i++) begin
      repeat (3) @(posedge clk);
      pulse_update(vecs[i].value, vecs[i].dp, vecs[i].en);
      wait_frame($sformatf("vec%0d", i), i == 0);
      check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dpn);
    end

    // Two updates in one frame: the later one is what gets committed.
    repeat (3) @(posedge clk);
    pulse_update(16'hAAAA, 4'b0000, 4'b1111);
    repeat (3) @(negedge clk);
    pulse_update(16'hBEEF, 4'b0000, 4'b1111);
    wait_frame("multi", 1'b0);
    check_frame("multi", {7'h03, 7'h06, 7'h06, 7'h0E}, 4'b1111);

    // Update asserted exactly on the wrap edge: shown in the frame starting at that edge.
    @(negedge clk);
    bus.value    = 16'h0C0A;
    bus.dp_in    = 4'b1000;
    bus.digit_en = 4'b1111;
    bus.update   = 1'b1;
    @(posedge clk);
    #1;
    bus.update   = 1'b0;
    check_frame("wrapupd", {7'h40, 7'h46, 7'h40, 7'h08}, 4'b0111);
    @(posedge clk);
    #1;
    check_frame("wrapupd2", {7'h40, 7'h46, 7'h40, 7'h08}, 4'b0111);

    // Async reset in the middle of digit 2's slot, between clock edges.
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 64 && !seen; n++) begin
        @(posedge clk);
        #1;
        if (bus.digit_sel == 2'd2) seen = 1'b1;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL async-reset setup: digit_sel never reached 2, expected 2 within 64 cycles");
      end
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async sel", 32'(bus.digit_sel), 32'h0);
    chk("async seg", 32'(bus.seg_n), 32'h7F);
    chk("async dp", 32'(bus.dp_n), 32'h1);
    chk("async fdone", 32'(bus.frame_done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_after_reset("async-restart", 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed scanner for a 4-digit seven-segment display. It produces the 2-bit digit index that feeds the 2-to-4 digit decoder downstream, which drives the one-hot anode enables. In lockstep with that index it drives the active-low cathode pattern for the selected hex nibble. Captured data is committed only at frame boundaries, so a displayed frame is never torn.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 1000, cycles at the start of each slot with all cathodes off for ghost suppression (0 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
value  input  16  four hex digits; digit 0 = value[3:0] (rightmost)
dp_in  input  4  decimal-point enables per digit, 1 = lit
digit_en  input  4  per-digit enable; 0 = digit blanked
update  input  1  one-cycle strobe; captures value/dp_in/digit_en
digit_sel  output  2  current digit index, to the 2-to-4 decoder
seg_n  output  7  cathodes, active-low, seg_n[6:0] = g,f,e,d,c,b,a
dp_n  output  1  decimal-point cathode, active-low
frame_done  output  1  one-cycle pulse when digit_sel wraps 3 -> 0

Behaviour:
- One clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values (immediate on rst_n low, no clock needed):
  - prescaler = 0, digit_sel = 0
  - staging and display registers all 0, display digit_en = 0
  - pending = 0, seg_n = 7'h7F, dp_n = 1, frame_done = 0
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - At terminal count it returns to 0 and digit_sel increments modulo 4 (3 -> 0).
- frame_done:
  - Asserted in exactly the one cycle in which digit_sel first shows 0 after a 3 -> 0 wrap.
  - Not asserted after reset release.
- Capture:
  - update = 1 loads staging from value/dp_in/digit_en and sets pending. Last write wins.
- Commit:
  - On the wrap edge, if pending, display regs load from staging and pending clears.
  - If update is high on the wrap edge itself, display loads directly from the inputs presented that cycle and pending clears.
  - Display regs never change at any other time.
- Outputs are all registered:
  - seg_n and dp_n are loaded from next-state index, prescaler and display values.
  - In every cycle, seg_n and dp_n correspond to the digit_sel visible in the same cycle. There is zero skew between index and cathodes.
- Blanking: seg_n = 7'h7F and dp_n = 1 when either condition holds:
  - prescaler < BLANK_CYCLES, or
  - display digit_en[digit_sel] = 0.
- Otherwise:
  - seg_n = hex pattern of display nibble [4*digit_sel+3 : 4*digit_sel].
  - dp_n = ~display dp[digit_sel].
- Hex patterns (seg_n, hex):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Reset mid-slot: all state returns to reset values asynchronously. Scanning restarts at digit 0, prescaler 0, on the first edge after rst_n rises.
- BLANK_CYCLES = 0: no blank window; the pattern is shown for the whole slot.

Test Plan:
(REFRESH_DIV = 8, BLANK_CYCLES = 2 unless noted)
1. Reset: hold rst_n low 3 cycles, then release -> digit_sel = 0, seg_n = 7F, dp_n = 1, frame_done = 0. The first digit_sel change (to 1) occurs 8 cycles after release.
2. Commit: update with value = 16'h1234, digit_en = F, dp_in = 0 -> display is unchanged (blank) until the wrap. frame_done pulses for 1 cycle at the wrap. In the next frame, unblanked cycles show digit 0 = 19, digit 1 = 30, digit 2 = 24, digit 3 = 79.
3. Slot timing: within each slot, cycles 0-1 give seg_n = 7F and cycles 2-7 give the pattern. digit_sel sequence is 0,1,2,3,0 at 8-cycle spacing. frame_done period = 32 cycles.
4. Enables and points: digit_en = 4'b0011, dp_in = 4'b0001, value = 16'h00F0 -> digits 2-3 stay 7F for the whole slot. Digit 1 shows 0E. Digit 0 shows 40 with dp_n = 0 on cycles 2-7.
5. Multiple updates: update 16'hAAAA, then 16'hBEEF in the same frame -> only BEEF is committed at the wrap: digit 3 = 03, digit 2 = 06, digit 1 = 06, digit 0 = 0E. Separately, update asserted exactly on the wrap edge -> those inputs are displayed immediately in the new frame.
6. Async reset: drop rst_n mid-slot of digit 2, between clock edges -> digit_sel = 0, seg_n = 7F, frame_done = 0 with no clock edge. After release, the frame restarts from digit 0 with display blank.
